// File: rtl/wash_pkg.sv
// Shared types and defaults for the washer scheduler: FSM state encoding and parameter defaults.
package wash_pkg;

   localparam int STATE_W     = 3;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_TIMEOUT = 64;
   localparam int DEF_CNT_W   = 8;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 3'd0,
      GRANT   = 3'd1,
      START   = 3'd2,
      RUN     = 3'd3,
      UNLOAD  = 3'd4,
      RELEASE = 3'd5
   } state_t;

endpackage

// File: rtl/wash_scheduler_if.sv
// Requester and washer handshake bundle; master is the scheduler side, slave the requesters/washer.
interface wash_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 8
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] dbl_req;
   logic [NUM_REQ-1:0] grant;
   logic               busy;
   logic               wm_coin_insert;
   logic               wm_double_wash;
   logic               wm_lid;
   logic               wm_laundry_done;
   logic               wm_double_wash_done;
   logic               wm_lid_done;
   logic               timeout_err;
   logic [CNT_W-1:0]   served_cnt;

   modport master (
      input  req, dbl_req, wm_laundry_done, wm_double_wash_done, wm_lid_done,
      output grant, busy, wm_coin_insert, wm_double_wash, wm_lid, timeout_err, served_cnt
   );

   modport slave (
      output req, dbl_req, wm_laundry_done, wm_double_wash_done, wm_lid_done,
      input  grant, busy, wm_coin_insert, wm_double_wash, wm_lid, timeout_err, served_cnt
   );
endinterface

// File: rtl/wash_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping; zero latency.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] sel,
   output logic [IDX_W-1:0]   idx,
   output logic               vld
);
   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

   logic [IDX_W:0] pos;

   always_comb begin
      sel = '0;
      idx = '0;
      vld = 1'b0;
      pos = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // ptr + i never reaches 2*NUM_REQ, so one subtraction wraps it
         pos = {1'b0, ptr} + (IDX_W+1)'(i);
         if (pos >= N_W) begin
            pos = pos - N_W;
         end
         if (!vld && req[pos[IDX_W-1:0]]) begin
            vld                  = 1'b1;
            sel[pos[IDX_W-1:0]]  = 1'b1;
            idx                  = pos[IDX_W-1:0];
         end
      end
   end
endmodule

// File: rtl/wash_scheduler.sv
// Round-robin share of one washer; grant 1 cycle after req, coin 2 cycles after; waits on done/lid pulses.
// WASH_STATS_EN enables the served-wash counter (otherwise served_cnt is tied to 0).
module wash_scheduler
   import wash_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input logic              clk,
   input logic              rst,
   wash_scheduler_if.master bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT) + 1;
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_REQ - 1);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   sel_idx;
   logic               dbl_r;
   logic [WD_W-1:0]    wd;
   logic [NUM_REQ-1:0] grant_r;
   logic               busy_r;
   logic               coin_r;
   logic               dbl_o;
   logic               lid_r;
   logic               terr_r;

   logic [NUM_REQ-1:0] arb_sel;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_vld;
   logic [WD_W-1:0]    wd_inc;
   logic               done_hit;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req (bus.req),
      .ptr (ptr),
      .sel (arb_sel),
      .idx (arb_idx),
      .vld (arb_vld)
   );

   assign wd_inc   = wd + 1'b1;
   // only the done pulse matching the latched wash mode counts
   assign done_hit = dbl_r ? bus.wm_double_wash_done : bus.wm_laundry_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         ptr     <= '0;
         sel_idx <= '0;
         dbl_r   <= 1'b0;
         wd      <= '0;
         grant_r <= '0;
         busy_r  <= 1'b0;
         coin_r  <= 1'b0;
         dbl_o   <= 1'b0;
         lid_r   <= 1'b0;
         terr_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_vld) begin
                  state   <= GRANT;
                  grant_r <= arb_sel;
                  sel_idx <= arb_idx;
                  dbl_r   <= bus.dbl_req[arb_idx];
                  busy_r  <= 1'b1;
               end
            end
            GRANT: begin
               state  <= START;
               coin_r <= 1'b1;
               dbl_o  <= dbl_r;
            end
            START: begin
               state  <= RUN;
               coin_r <= 1'b0;
               wd     <= '0;
            end
            RUN: begin
               wd <= wd_inc;
               if (done_hit) begin
                  state <= UNLOAD;
                  dbl_o <= 1'b0;
                  lid_r <= 1'b1;
               end else if (wd_inc == WD_LAST) begin
                  state  <= UNLOAD;
                  dbl_o  <= 1'b0;
                  lid_r  <= 1'b1;
                  terr_r <= 1'b1;
               end
            end
            UNLOAD: begin
               if (bus.wm_lid_done) begin
                  state <= RELEASE;
                  lid_r <= 1'b0;
               end
            end
            RELEASE: begin
               state   <= IDLE;
               grant_r <= '0;
               busy_r  <= 1'b0;
               ptr     <= (sel_idx == IDX_TOP) ? '0 : sel_idx + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.grant          = grant_r;
   assign bus.busy           = busy_r;
   assign bus.wm_coin_insert = coin_r;
   assign bus.wm_double_wash = dbl_o;
   assign bus.wm_lid         = lid_r;
   assign bus.timeout_err    = terr_r;

`ifdef WASH_STATS_EN
   logic [CNT_W-1:0] served_r;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         served_r <= '0;
      end else if (state == RUN && done_hit) begin
         served_r <= served_r + 1'b1;
      end
   end

   assign bus.served_cnt = served_r;
`else
   assign bus.served_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_wash_scheduler.sv
// Directed bench for wash_scheduler: single, double-wash, round-robin, timeout and async-reset scenarios.
module tb_wash_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wash_scheduler_if #(.NUM_REQ(4), .CNT_W(8)) ifc ();

   wash_scheduler #(.NUM_REQ(4), .TIMEOUT(64), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int errors   = 0;
   int checks   = 0;
   int coin_cnt = 0;

   always @(negedge clk) if (ifc.wm_coin_insert) coin_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
   endtask

   task automatic wait_grant(input string tag, input logic [3:0] exp);
      int n = 0;
      while (ifc.grant == 4'b0 && n < 20) begin
         tick(1);
         n++;
      end
      check({tag, "_grant"}, 32'(ifc.grant), 32'(exp));
   endtask

   task automatic wash(input string tag, input logic [3:0] exp_grant, input logic dbl,
                       input int delay, input logic wrong, input logic drop);
      int c0 = coin_cnt;
      wait_grant(tag, exp_grant);
      if (drop) ifc.req = 4'b0;
      tick(1);
      check({tag, "_coin"}, 32'(ifc.wm_coin_insert), 32'd1);
      check({tag, "_dbl_start"}, 32'(ifc.wm_double_wash), 32'(dbl));
      tick(1);
      check({tag, "_coin_off"}, 32'(ifc.wm_coin_insert), 32'd0);
      if (wrong) begin
         if (dbl) ifc.wm_laundry_done = 1'b1;
         else     ifc.wm_double_wash_done = 1'b1;
         tick(1);
         ifc.wm_laundry_done     = 1'b0;
         ifc.wm_double_wash_done = 1'b0;
         check({tag, "_wrong_ignored"}, 32'(ifc.wm_lid), 32'd0);
         check({tag, "_dbl_run"}, 32'(ifc.wm_double_wash), 32'(dbl));
      end
      tick(delay);
      if (dbl) ifc.wm_double_wash_done = 1'b1;
      else     ifc.wm_laundry_done = 1'b1;
      tick(1);
      ifc.wm_laundry_done     = 1'b0;
      ifc.wm_double_wash_done = 1'b0;
      check({tag, "_lid"}, 32'(ifc.wm_lid), 32'd1);
      check({tag, "_dbl_off"}, 32'(ifc.wm_double_wash), 32'd0);
      tick(2);
      check({tag, "_lid_hold"}, 32'(ifc.wm_lid), 32'd1);
      ifc.wm_lid_done = 1'b1;
      tick(1);
      ifc.wm_lid_done = 1'b0;
      check({tag, "_lid_off"}, 32'(ifc.wm_lid), 32'd0);
      check({tag, "_grant_rel"}, 32'(ifc.grant), 32'(exp_grant));
      tick(1);
      check({tag, "_grant_clr"}, 32'(ifc.grant), 32'd0);
      check({tag, "_busy_clr"}, 32'(ifc.busy), 32'd0);
      check({tag, "_coins"}, 32'(coin_cnt - c0), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got=stuck exp=finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      int n;
      int exp_served;
      ifc.req                 = 4'b0;
      ifc.dbl_req             = 4'b0;
      ifc.wm_laundry_done     = 1'b0;
      ifc.wm_double_wash_done = 1'b0;
      ifc.wm_lid_done         = 1'b0;
      #1;
      check("rst_grant", 32'(ifc.grant), 32'd0);
      check("rst_busy", 32'(ifc.busy), 32'd0);
      check("rst_coin", 32'(ifc.wm_coin_insert), 32'd0);
      check("rst_lid", 32'(ifc.wm_lid), 32'd0);
      check("rst_terr", 32'(ifc.timeout_err), 32'd0);
      check("rst_served", 32'(ifc.served_cnt), 32'd0);
      do_reset();

`ifdef WASH_STATS_EN
      exp_served = 1;
`else
      exp_served = 0;
`endif

      // single request, single wash
      ifc.req = 4'b0001;
      wash("single", 4'b0001, 1'b0, 10, 1'b0, 1'b1);
      check("single_served", 32'(ifc.served_cnt), 32'(exp_served));

      // double wash with a stray single-wash done
      do_reset();
      ifc.req     = 4'b0100;
      ifc.dbl_req = 4'b0100;
      wash("dbl", 4'b0100, 1'b1, 5, 1'b1, 1'b1);
      ifc.dbl_req = 4'b0;

      // round-robin fairness with all requests held
      do_reset();
      ifc.req = 4'b1111;
      wash("rr0", 4'b0001, 1'b0, 3, 1'b0, 1'b0);
      wash("rr1", 4'b0010, 1'b0, 3, 1'b0, 1'b0);
      wash("rr2", 4'b0100, 1'b0, 3, 1'b0, 1'b0);
      wash("rr3", 4'b1000, 1'b0, 3, 1'b0, 1'b0);
      wait_grant("rr4", 4'b0001);
      ifc.req = 4'b0;

      // watchdog abort; requester drops req mid-cycle
      do_reset();
      ifc.req = 4'b0010;
      wait_grant("to", 4'b0010);
      ifc.req = 4'b0;
      tick(1);
      check("to_coin", 32'(ifc.wm_coin_insert), 32'd1);
      n = 0;
      while (!ifc.wm_lid && n < 100) begin
         tick(1);
         n++;
      end
      check("to_unload_cycles", 32'(n), 32'd64);
      check("to_terr", 32'(ifc.timeout_err), 32'd1);
      check("to_served", 32'(ifc.served_cnt), 32'd0);
      check("to_busy", 32'(ifc.busy), 32'd1);
      ifc.wm_lid_done = 1'b1;
      tick(1);
      ifc.wm_lid_done = 1'b0;
      tick(1);
      check("to_terr_sticky", 32'(ifc.timeout_err), 32'd1);
      check("to_busy_clr", 32'(ifc.busy), 32'd0);
      ifc.req     = 4'b0111;
      ifc.dbl_req = 4'b0100;
      wait_grant("to_ptr", 4'b0100);

      // async reset in the middle of RUN
      ifc.req = 4'b0;
      tick(3);
      check("mid_dbl_pre", 32'(ifc.wm_double_wash), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_grant", 32'(ifc.grant), 32'd0);
      check("mid_busy", 32'(ifc.busy), 32'd0);
      check("mid_coin", 32'(ifc.wm_coin_insert), 32'd0);
      check("mid_dbl", 32'(ifc.wm_double_wash), 32'd0);
      check("mid_lid", 32'(ifc.wm_lid), 32'd0);
      check("mid_terr", 32'(ifc.timeout_err), 32'd0);
      ifc.dbl_req = 4'b0;
      tick(1);
      rst     = 1'b1;
      ifc.req = 4'b1000;
      tick(1);
      wait_grant("post_rst", 4'b1000);
      ifc.req = 4'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
